// File: rtl/weight_bias_update_seq_if.sv
// weight_bias_update_seq_if
//   Bundles the control, operand, load and parameter-view signals of the
//   weight/bias update engine.
//   master : drives i_* (controller / testbench), observes o_*
//   slave  : the update engine itself
//   Signals: i_start, i_load, i_lr, i_mu, i_k, i_hd_a, i_dlto, i_dlth,
//            i_wght_hd, i_wght_o, i_bias_hd, i_bias_o (inputs to engine)
//            o_busy, o_done, o_wght_hd, o_wght_o, o_bias_hd, o_bias_o
interface weight_bias_update_seq_if #(
  parameter int N_IN   = 2,
  parameter int N_HL_P = 3,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32
);
  logic                           i_start;
  logic                           i_load;
  logic [WIDTH-1:0]               i_lr;
  logic [WIDTH-1:0]               i_mu;
  logic [N_IN*WIDTH-1:0]          i_k;
  logic [N_HL_P*WIDTH-1:0]        i_hd_a;
  logic [N_OUT*WIDTH-1:0]         i_dlto;
  logic [N_HL_P*WIDTH-1:0]        i_dlth;
  logic [N_HL_P*N_IN*WIDTH-1:0]   i_wght_hd;
  logic [N_OUT*N_HL_P*WIDTH-1:0]  i_wght_o;
  logic [N_HL_P*WIDTH-1:0]        i_bias_hd;
  logic [N_OUT*WIDTH-1:0]         i_bias_o;
  logic                           o_busy;
  logic                           o_done;
  logic [N_HL_P*N_IN*WIDTH-1:0]   o_wght_hd;
  logic [N_OUT*N_HL_P*WIDTH-1:0]  o_wght_o;
  logic [N_HL_P*WIDTH-1:0]        o_bias_hd;
  logic [N_OUT*WIDTH-1:0]         o_bias_o;

  modport master (
    output i_start, i_load, i_lr, i_mu, i_k, i_hd_a, i_dlto, i_dlth,
           i_wght_hd, i_wght_o, i_bias_hd, i_bias_o,
    input  o_busy, o_done, o_wght_hd, o_wght_o, o_bias_hd, o_bias_o
  );

  modport slave (
    input  i_start, i_load, i_lr, i_mu, i_k, i_hd_a, i_dlto, i_dlth,
           i_wght_hd, i_wght_o, i_bias_hd, i_bias_o,
    output o_busy, o_done, o_wght_hd, o_wght_o, o_bias_hd, o_bias_o
  );
endinterface

// File: rtl/weight_bias_update_seq.sv
// weight_bias_update_seq
//   Register store for all hidden/output weights and biases of a
//   1-hidden-layer ANN plus a sequential gradient-descent updater. A start
//   request captures the operands, then one parameter per cycle is pushed
//   through a single shared datapath:
//     g = sat((delta*act)>>>FRAC), s = sat((lr*g)>>>FRAC), w = sat(w - s)
//   Ports: clk, rst (synchronous, active high), bus (slave modport of
//   weight_bias_update_seq_if carrying control, operands, load values,
//   busy/done and the parameter views).
//   Optional feature: define MOMENTUM_EN to add one velocity register per
//   parameter; then v = sat(((mu*v)>>>FRAC) + s) and w = sat(w - v).
module weight_bias_update_seq #(
  parameter int N_IN   = 2,
  parameter int N_HL_P = 3,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32,
  parameter int FRAC   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  weight_bias_update_seq_if.slave bus
);

  // Flat parameter index map: hidden weights, hidden biases, output weights, output biases.
  localparam int OFF_HB = N_HL_P * N_IN;
  localparam int OFF_OW = OFF_HB + N_HL_P;
  localparam int OFF_OB = OFF_OW + N_OUT * N_HL_P;
  localparam int TOTAL  = OFF_OB + N_OUT;
  localparam int IW     = $clog2(TOTAL);
  localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);
  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state_r, state_s;
  logic   busy_r, done_r;
  logic   load_s, cap_s, upd_s;
  logic [IW-1:0] idx_r;

  logic signed [WIDTH-1:0] p_r    [TOTAL];
  logic signed [WIDTH-1:0] lr_r;
  logic signed [WIDTH-1:0] k_r    [N_IN];
  logic signed [WIDTH-1:0] hda_r  [N_HL_P];
  logic signed [WIDTH-1:0] dlto_r [N_OUT];
  logic signed [WIDTH-1:0] dlth_r [N_HL_P];

  logic signed [WIDTH-1:0] dsel_s [TOTAL];
  logic signed [WIDTH-1:0] asel_s [TOTAL];
  logic signed [WIDTH-1:0] delta_s, act_s, g_s, s_s, w_new_s;

`ifdef MOMENTUM_EN
  logic signed [WIDTH-1:0] mu_r;
  logic signed [WIDTH-1:0] v_r [TOTAL];
  logic signed [WIDTH-1:0] v_new_s;
`else
  logic unused_mu_s;
  assign unused_mu_s = ^bus.i_mu;
`endif

  function automatic logic signed [2*WIDTH-1:0] ext(input logic signed [WIDTH-1:0] x);
    ext = {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [2*WIDTH-1:0] x);
    logic signed [2*WIDTH-1:0] maxv;
    logic signed [2*WIDTH-1:0] minv;
    maxv = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    minv = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if (x > maxv) begin
      sat = maxv[WIDTH-1:0];
    end else if (x < minv) begin
      sat = minv[WIDTH-1:0];
    end else begin
      sat = x[WIDTH-1:0];
    end
  endfunction

  // Full-width fixed-point multiply, arithmetic shift (floor), then clamp.
  function automatic logic signed [WIDTH-1:0] mul_q(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p     = ext(a) * ext(b);
    mul_q = sat(p >>> FRAC);
  endfunction

  // Next-state and sweep control decode.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    cap_s   = 1'b0;
    upd_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_load) begin
          load_s = 1'b1;
        end else if (bus.i_start) begin
          cap_s   = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        upd_s = 1'b1;
        if (idx_r == LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Per-index gradient operand tables built from the captured operands.
  always_comb begin
    for (int n = 0; n < TOTAL; n++) begin
      dsel_s[n] = '0;
      asel_s[n] = '0;
    end
    for (int j = 0; j < N_HL_P; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        dsel_s[j*N_IN+i] = dlth_r[j];
        asel_s[j*N_IN+i] = k_r[i];
      end
      dsel_s[OFF_HB+j] = dlth_r[j];
      asel_s[OFF_HB+j] = ONE;
    end
    for (int k = 0; k < N_OUT; k++) begin
      for (int j = 0; j < N_HL_P; j++) begin
        dsel_s[OFF_OW+k*N_HL_P+j] = dlto_r[k];
        asel_s[OFF_OW+k*N_HL_P+j] = hda_r[j];
      end
      dsel_s[OFF_OB+k] = dlto_r[k];
      asel_s[OFF_OB+k] = ONE;
    end
  end

  // Shared update datapath for the parameter selected by idx_r.
  always_comb begin
    delta_s = dsel_s[idx_r];
    act_s   = asel_s[idx_r];
    g_s     = mul_q(delta_s, act_s);
    s_s     = mul_q(lr_r, g_s);
`ifdef MOMENTUM_EN
    v_new_s = sat(((ext(mu_r) * ext(v_r[idx_r])) >>> FRAC) + ext(s_s));
    w_new_s = sat(ext(p_r[idx_r]) - ext(v_new_s));
`else
    w_new_s = sat(ext(p_r[idx_r]) - ext(s_s));
`endif
  end

  // Parameter store, operand capture and sweep index.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= '0;
      lr_r  <= '0;
      for (int n = 0; n < TOTAL; n++) p_r[n] <= '0;
      for (int i = 0; i < N_IN; i++) k_r[i] <= '0;
      for (int j = 0; j < N_HL_P; j++) begin
        hda_r[j]  <= '0;
        dlth_r[j] <= '0;
      end
      for (int k = 0; k < N_OUT; k++) dlto_r[k] <= '0;
`ifdef MOMENTUM_EN
      mu_r <= '0;
      for (int n = 0; n < TOTAL; n++) v_r[n] <= '0;
`endif
    end else if (load_s) begin
      for (int n = 0; n < OFF_HB; n++) p_r[n] <= bus.i_wght_hd[n*WIDTH +: WIDTH];
      for (int j = 0; j < N_HL_P; j++) p_r[OFF_HB+j] <= bus.i_bias_hd[j*WIDTH +: WIDTH];
      for (int n = 0; n < N_OUT*N_HL_P; n++) p_r[OFF_OW+n] <= bus.i_wght_o[n*WIDTH +: WIDTH];
      for (int k = 0; k < N_OUT; k++) p_r[OFF_OB+k] <= bus.i_bias_o[k*WIDTH +: WIDTH];
`ifdef MOMENTUM_EN
      for (int n = 0; n < TOTAL; n++) v_r[n] <= '0;
`endif
    end else if (cap_s) begin
      idx_r <= '0;
      lr_r  <= bus.i_lr;
      for (int i = 0; i < N_IN; i++) k_r[i] <= bus.i_k[i*WIDTH +: WIDTH];
      for (int j = 0; j < N_HL_P; j++) begin
        hda_r[j]  <= bus.i_hd_a[j*WIDTH +: WIDTH];
        dlth_r[j] <= bus.i_dlth[j*WIDTH +: WIDTH];
      end
      for (int k = 0; k < N_OUT; k++) dlto_r[k] <= bus.i_dlto[k*WIDTH +: WIDTH];
`ifdef MOMENTUM_EN
      mu_r <= bus.i_mu;
`endif
    end else if (upd_s) begin
      p_r[idx_r] <= w_new_s;
`ifdef MOMENTUM_EN
      v_r[idx_r] <= v_new_s;
`endif
      idx_r <= (idx_r == LAST) ? '0 : idx_r + {{(IW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.o_busy = busy_r;
  assign bus.o_done = done_r;

  // Outputs are direct views of the parameter registers.
  for (genvar n = 0; n < OFF_HB; n++) begin : g_ohw
    assign bus.o_wght_hd[n*WIDTH +: WIDTH] = p_r[n];
  end
  for (genvar j = 0; j < N_HL_P; j++) begin : g_ohb
    assign bus.o_bias_hd[j*WIDTH +: WIDTH] = p_r[OFF_HB+j];
  end
  for (genvar n = 0; n < N_OUT*N_HL_P; n++) begin : g_oow
    assign bus.o_wght_o[n*WIDTH +: WIDTH] = p_r[OFF_OW+n];
  end
  for (genvar k = 0; k < N_OUT; k++) begin : g_oob
    assign bus.o_bias_o[k*WIDTH +: WIDTH] = p_r[OFF_OB+k];
  end

endmodule
